// File: rtl/muldiv_hilo_unit.sv
// muldiv_hilo_unit: multi-cycle mult/div unit owning the architectural HI/LO registers
module muldiv_hilo_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             we,
  input  logic             hi_sel,
  input  logic [WIDTH-1:0] wdata,
  input  logic             cancel,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             hazard
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  logic [CW-1:0]      count_q, count_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, phi_q, phi_d, plo_q, plo_d;
  logic [2*WIDTH-1:0] ax, bx, prod;
  logic [WIDTH-1:0]   ua, ub, uq, ur, q, r, res_hi, res_lo;
  logic               sa, sb, dz, accept, last;
  assign busy   = count_q != '0;
  assign hazard = busy | (start & ~cancel);
  assign accept = start & ~cancel & ~busy;
  assign last   = count_q == CW'(1);
  assign hi     = hi_q;
  assign lo     = lo_q;
  // Signed divide works on magnitudes, so the most-negative / -1 case falls out
  // as lo = a, hi = 0 without a dedicated path or a trapping signed divide.
  always_comb begin
    ax     = op[0] ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    bx     = op[0] ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    prod   = ax * bx;
    sa     = op[0] & a[WIDTH-1];
    sb     = op[0] & b[WIDTH-1];
    dz     = b == '0;
    ua     = sa ? -a : a;
    ub     = dz ? WIDTH'(1) : (sb ? -b : b);
    uq     = ua / ub;
    ur     = ua % ub;
    q      = (sa ^ sb) ? -uq : uq;
    r      = sa ? -ur : ur;
    res_hi = op[1] ? (dz ? a : r) : prod[2*WIDTH-1:WIDTH];
    res_lo = op[1] ? (dz ? '1 : q) : prod[WIDTH-1:0];
  end
  always_comb begin
    count_d = busy ? (cancel ? '0 : count_q - CW'(1))
                   : (accept ? (op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES)) : count_q);
    phi_d   = accept ? res_hi : phi_q;
    plo_d   = accept ? res_lo : plo_q;
    hi_d    = (busy & last & ~cancel) ? phi_q : (~busy & ~start & we & hi_sel) ? wdata : hi_q;
    lo_d    = (busy & last & ~cancel) ? plo_q : (~busy & ~start & we & ~hi_sel) ? wdata : lo_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
    end else begin
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
    end
  end
  start_while_busy: assert property (@(posedge clk) disable iff (!rst_n) !(start && busy))
    else $warning("muldiv_hilo_unit: start issued while busy, ignored");
endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// tb_muldiv_hilo_unit: directed checks of the 32-bit and 16-bit unit configurations
module tb_muldiv_hilo_unit;
  logic        clk = 0, rst_n, start, we, hi_sel, cancel, sel;
  logic [1:0]  op;
  logic [31:0] a, b, wdata, hi32, lo32, hi_o, lo_o, msk;
  logic [15:0] hi16, lo16;
  logic        busy32, haz32, busy16, haz16, busy_o, haz_o;
  int          mc, dc;
  int          checks = 0, errors = 0;
  always #5 clk = ~clk;
  muldiv_hilo_unit u32 (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel), .op(op), .a(a), .b(b),
    .we(we & ~sel), .hi_sel(hi_sel), .wdata(wdata), .cancel(cancel & ~sel),
    .hi(hi32), .lo(lo32), .busy(busy32), .hazard(haz32));
  muldiv_hilo_unit #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start & sel), .op(op), .a(a[15:0]), .b(b[15:0]),
    .we(we & sel), .hi_sel(hi_sel), .wdata(wdata[15:0]), .cancel(cancel & sel),
    .hi(hi16), .lo(lo16), .busy(busy16), .hazard(haz16));
  assign hi_o   = sel ? {16'h0, hi16} : hi32;
  assign lo_o   = sel ? {16'h0, lo16} : lo32;
  assign busy_o = sel ? busy16 : busy32;
  assign haz_o  = sel ? haz16 : haz32;
  assign msk    = sel ? 32'h0000FFFF : 32'hFFFFFFFF;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL w%0d %s: got %h expected %h", sel ? 16 : 32, tag, got, exp);
    end
  endtask
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1;
    #1 chk("hazard_issue", 32'(haz_o), 1);
    @(posedge clk); #1;
    start = 0;
  endtask
  task automatic wait_done(input string tag, input int n);
    int k = 0;
    while (busy_o && k < 64) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_busy_len"}, k, n);
  endtask
  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo);
    issue(o, x, y);
    wait_done(tag, o[1] ? dc : mc);
    chk({tag, "_hi"}, hi_o, ehi & msk);
    chk({tag, "_lo"}, lo_o, elo & msk);
  endtask
  task automatic mt(input logic h, input logic [31:0] d);
    we = 1; hi_sel = h; wdata = d;
    @(posedge clk); #1;
    we = 0;
  endtask
  task automatic cancel_at(input string tag, input int j);
    issue(2'b01, 3, 4);
    repeat (j - 1) begin @(posedge clk); #1; end
    chk({tag, "_busy_pre"}, 32'(busy_o), 1);
    cancel = 1;
    @(posedge clk); #1;
    cancel = 0;
    chk({tag, "_busy_post"}, 32'(busy_o), 0);
    repeat (mc + 1) @(posedge clk);
    #1;
    chk({tag, "_hi"}, hi_o, 32'h11111111 & msk);
    chk({tag, "_lo"}, lo_o, 32'h11111111 & msk);
  endtask
  task automatic suite();
    run("mult",   2'b01, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run("multu",  2'b00, 32'hFFFFFFFE, 32'h3, 32'h00000002, 32'hFFFFFFFA);
    run("div",    2'b11, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run("divu",   2'b10, 32'h7, 32'h2, 32'h1, 32'h3);
    run("divu0",  2'b10, 32'h7, 32'h0, 32'h7, 32'hFFFFFFFF);
    run("divovf", 2'b11, sel ? 32'h8000 : 32'h80000000, 32'hFFFFFFFF, 32'h0,
        sel ? 32'h8000 : 32'h80000000);
    mt(1, 32'h12345678);
    chk("mthi_busy", 32'(busy_o), 0);
    chk("mthi_hi", hi_o, 32'h12345678 & msk);
    issue(2'b01, 3, 4);
    we = 1; hi_sel = 0; wdata = 32'hAAAA5555;
    @(posedge clk); #1;
    we = 0;
    wait_done("mtlo_busy", mc - 1);
    chk("mtlo_busy_lo", lo_o, 32'd12);
    chk("mtlo_busy_hi", hi_o, 32'd0);
    issue(2'b01, 3, 4);
    op = 2'b10; a = 100; b = 7; start = 1;
    @(posedge clk); #1;
    start = 0;
    wait_done("restart", mc - 1);
    repeat (dc + 1) @(posedge clk);
    #1;
    chk("restart_busy", 32'(busy_o), 0);
    chk("restart_lo", lo_o, 32'd12);
    chk("restart_hi", hi_o, 32'd0);
    mt(1, 32'h11111111);
    mt(0, 32'h11111111);
    cancel_at("cancel_mid", mc < 3 ? mc : 3);
    cancel_at("cancel_last", mc);
    op = 2'b01; a = 3; b = 4; start = 1; cancel = 1;
    #1 chk("startcancel_hazard", 32'(haz_o), 0);
    @(posedge clk); #1;
    start = 0; cancel = 0;
    chk("startcancel_busy", 32'(busy_o), 0);
    repeat (mc + 1) @(posedge clk);
    #1;
    chk("startcancel_lo", lo_o, 32'h11111111 & msk);
    issue(2'b11, 100, 7);
    @(posedge clk); #1;
    chk("rst_pre_busy", 32'(busy_o), 1);
    rst_n = 0;
    #1;
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_hi", hi_o, 0);
    chk("rst_lo", lo_o, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    run("multu_ff", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
  endtask
  initial begin
    sel = 0; rst_n = 0; start = 0; we = 0; hi_sel = 0; cancel = 0;
    op = 0; a = 0; b = 0; wdata = 0; mc = 5; dc = 10;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hi", hi_o, 0);
    chk("reset_lo", lo_o, 0);
    chk("reset_busy", 32'(busy_o), 0);
    chk("reset_hazard", 32'(haz_o), 0);
    rst_n = 1;
    suite();
    sel = 1; mc = 1; dc = 3;
    @(posedge clk); #1;
    suite();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
